// File: rtl/aidan_mcnay_change_emit_pkg.sv
// Shared definitions for the change-emit transmitter.
//   state_e     : FSM encoding (LP_IDLE / LP_HOLD)
//   hold_width  : width of the hold counter for a given minimum hold,
//                 never narrower than one bit.
`ifndef AIDAN_MCNAY_CHANGE_EMIT_PKG_SV
`define AIDAN_MCNAY_CHANGE_EMIT_PKG_SV
package aidan_mcnay_change_emit_pkg;

    typedef enum logic {
        LP_IDLE = 1'b0,
        LP_HOLD = 1'b1
    } state_e;

    function automatic int hold_width(input int min_hold);
        int w;
        w = $clog2(min_hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`endif

// File: rtl/aidan_mcnay_change_emit_if.sv
// Event/status bundle of the change-emit transmitter.
//   in_pulse, clr_overflow           : requester -> transmitter
//   out_signal, out_busy,
//   out_pending, out_overflow        : transmitter -> requester / line
// master = the side issuing events, slave = the transmitter.
// p_cnt_bits must match the transmitter's p_cnt_bits.
interface aidan_mcnay_change_emit_if #(
    parameter int p_cnt_bits = 4
);
    logic                  in_pulse;
    logic                  clr_overflow;
    logic                  out_signal;
    logic                  out_busy;
    logic [p_cnt_bits-1:0] out_pending;
    logic                  out_overflow;

    modport master (
        output in_pulse, clr_overflow,
        input  out_signal, out_busy, out_pending, out_overflow
    );

    modport slave (
        input  in_pulse, clr_overflow,
        output out_signal, out_busy, out_pending, out_overflow
    );
endinterface

// File: rtl/aidan_mcnay_sat_counter.sv
// Saturating up/down counter holding the event backlog.
//   clk, rst : clock, synchronous active-high reset
//   inc, dec : count up / down this cycle (both together = no change)
//   count    : current value (registered)
//   sat_drop : combinational, high when an increment was refused because
//              the counter is already all-ones
module aidan_mcnay_sat_counter #(
    parameter int p_width = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    output logic [p_width-1:0] count,
    output logic               sat_drop
);
    logic [p_width-1:0] count_reg;
    logic [p_width-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        sat_drop   = 1'b0;
        if (inc && !dec) begin
            if (&count_reg) begin
                sat_drop = 1'b1;
            end else begin
                count_next = count_reg + p_width'(1);
            end
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - p_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/aidan_mcnay_change_emit.sv
// Change-signalling transmitter: every accepted event flips out_signal once.
// Events arriving during the minimum hold window are queued in a saturating
// backlog counter and replayed one toggle per hold window.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of aidan_mcnay_change_emit_if
//              (in_pulse, clr_overflow in; out_signal, out_busy,
//               out_pending, out_overflow out)
module aidan_mcnay_change_emit
    import aidan_mcnay_change_emit_pkg::*;
#(
    parameter int p_min_hold = 4,
    parameter int p_cnt_bits = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    aidan_mcnay_change_emit_if.slave      bus
);
    localparam int             HW          = hold_width(p_min_hold);
    localparam logic [HW-1:0]  HOLD_RELOAD = HW'(p_min_hold - 1);

    state_e                state_reg, state_next;
    logic [HW-1:0]         hold_reg, hold_next;
    logic                  signal_reg;
    logic                  overflow_reg;
    logic                  toggle;
    logic                  pend_inc;
    logic                  pend_dec;
    logic                  sat_drop;
    logic [p_cnt_bits-1:0] pending;

    aidan_mcnay_sat_counter #(
        .p_width (p_cnt_bits)
    ) u_backlog (
        .clk      (clk),
        .rst      (rst),
        .inc      (pend_inc),
        .dec      (pend_dec),
        .count    (pending),
        .sat_drop (sat_drop)
    );

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        toggle     = 1'b0;
        pend_inc   = 1'b0;
        pend_dec   = 1'b0;
        case (state_reg)
            LP_IDLE: begin
                // Backlog is always empty here, so a pulse goes straight out.
                if (bus.in_pulse) begin
                    toggle     = 1'b1;
                    state_next = LP_HOLD;
                    hold_next  = HOLD_RELOAD;
                end
            end
            LP_HOLD: begin
                if (hold_reg != '0) begin
                    hold_next = hold_reg - HW'(1);
                    pend_inc  = bus.in_pulse;
                end else if (pending != '0) begin
                    // Oldest queued event goes out; a concurrent pulse queues
                    // behind it, leaving the backlog count unchanged.
                    toggle    = 1'b1;
                    pend_dec  = 1'b1;
                    pend_inc  = bus.in_pulse;
                    hold_next = HOLD_RELOAD;
                end else if (bus.in_pulse) begin
                    toggle    = 1'b1;
                    hold_next = HOLD_RELOAD;
                end else begin
                    state_next = LP_IDLE;
                end
            end
            default: state_next = LP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LP_IDLE;
            hold_reg     <= '0;
            signal_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            signal_reg <= signal_reg ^ toggle;
            // A fresh drop outranks a clear in the same cycle.
            if (sat_drop) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign bus.out_signal   = signal_reg;
    assign bus.out_overflow = overflow_reg;
    assign bus.out_pending  = pending;
    assign bus.out_busy     = (state_reg == LP_HOLD) || (pending != '0);
endmodule

// File: tb/tb_aidan_mcnay_change_emit.sv
// Bench for aidan_mcnay_change_emit. Two instances share stimulus:
//   dut 0 : p_min_hold = 4, p_cnt_bits = 4
//   dut 1 : p_min_hold = 8, p_cnt_bits = 2
// A behavioural model tracks, per instance, the edges elapsed since the last
// toggle and the backlog as plain integers, and every step compares all
// outputs against it.
module tb_aidan_mcnay_change_emit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aidan_mcnay_change_emit_if #(.p_cnt_bits(4)) bus_a ();
    aidan_mcnay_change_emit_if #(.p_cnt_bits(2)) bus_b ();

    aidan_mcnay_change_emit #(.p_min_hold(4), .p_cnt_bits(4)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    aidan_mcnay_change_emit #(.p_min_hold(8), .p_cnt_bits(2)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural model state.
    int   m_since   [2];
    int   m_pending [2];
    logic m_sig     [2];
    logic m_ovf     [2];
    int   m_toggles [2];
    int   obs_toggles [2];
    logic obs_prev    [2];

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 15 : 3;
    endfunction

    function automatic void model_edge(input int d, input logic p, input logic c, input logic r);
        bit can_toggle;
        bit drop;
        if (r) begin
            m_since[d] = 1000; m_pending[d] = 0; m_sig[d] = 1'b0; m_ovf[d] = 1'b0;
            return;
        end
        drop       = 1'b0;
        can_toggle = (m_since[d] + 1 >= hold_of(d));
        if (can_toggle && (m_pending[d] > 0 || p)) begin
            m_sig[d] = ~m_sig[d];
            m_toggles[d]++;
            m_since[d] = 0;
            if (m_pending[d] > 0) m_pending[d] = m_pending[d] - 1 + int'(p);
        end else begin
            if (m_since[d] < 1000) m_since[d]++;
            if (p) begin
                if (m_pending[d] == max_of(d)) drop = 1'b1;
                else m_pending[d]++;
            end
        end
        if (drop) m_ovf[d] = 1'b1;
        else if (c) m_ovf[d] = 1'b0;
    endfunction

    function automatic logic [6:0] exp_vec(input int d);
        logic busy;
        busy = (m_since[d] < hold_of(d)) || (m_pending[d] != 0);
        return {m_sig[d], busy, m_ovf[d], 4'(m_pending[d])};
    endfunction

    function automatic logic [6:0] obs_vec(input int d);
        if (d == 0)
            return {bus_a.out_signal, bus_a.out_busy, bus_a.out_overflow, bus_a.out_pending};
        return {bus_b.out_signal, bus_b.out_busy, bus_b.out_overflow, 2'b00, bus_b.out_pending};
    endfunction

    // Drive one cycle of inputs, advance one edge, update model and
    // observed toggle counts (the bench acts as the change detector).
    task automatic step(input logic p, input logic c, input logic r);
        bus_a.in_pulse = p; bus_b.in_pulse = p;
        bus_a.clr_overflow = c; bus_b.clr_overflow = c;
        rst = r;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) model_edge(d, p, c, r);
        if (!r && bus_a.out_signal != obs_prev[0]) obs_toggles[0]++;
        if (!r && bus_b.out_signal != obs_prev[1]) obs_toggles[1]++;
        obs_prev[0] = bus_a.out_signal;
        obs_prev[1] = bus_b.out_signal;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            m_toggles[d] = 0; obs_toggles[d] = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs_vec(d) !== 7'h00) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), 7'h00);
                end
            end
        end
        clear_counts();
        step(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs_vec(d) !== exp_vec(d)) begin
                n_fail++;
                $display("FAIL reset_release dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus_a.out_signal !== 1'b1 || bus_a.out_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: got sig=%b busy=%b want sig=1 busy=1", bus_a.out_signal, bus_a.out_busy);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL single dut0 cyc%0d: got %h want %h", cyc, obs_vec(0), exp_vec(0));
            end
            if (i == 3) begin
                n_cmp++;
                if (bus_a.out_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy_end: got %b want 0", bus_a.out_busy);
                end
            end
        end
        n_cmp++;
        if (obs_toggles[0] !== 1) begin
            n_fail++;
            $display("FAIL single_toggles: got %0d want 1", obs_toggles[0]);
        end
    endtask

    task automatic test_burst();
        int peak;
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        peak = 0;
        for (int i = 0; i < 24; i++) begin
            step(i < 4, 1'b0, 1'b0);
            if (int'(bus_a.out_pending) > peak) peak = int'(bus_a.out_pending);
            n_cmp++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL burst dut0 cyc%0d: got %h want %h", cyc, obs_vec(0), exp_vec(0));
            end
        end
        n_cmp++;
        if (peak !== 3 || bus_a.out_pending !== 4'd0 || bus_a.out_signal !== 1'b0 || obs_toggles[0] !== 4) begin
            n_fail++;
            $display("FAIL burst_summary: got peak=%0d pend=%0d sig=%b tog=%0d want 3 0 0 4",
                     peak, bus_a.out_pending, bus_a.out_signal, obs_toggles[0]);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus_b.out_pending !== 2'd3 || bus_b.out_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_peak: got pend=%0d ovf=%b want 3 1", bus_b.out_pending, bus_b.out_overflow);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL sat dut1 cyc%0d: got %h want %h", cyc, obs_vec(1), exp_vec(1));
            end
        end
        n_cmp++;
        if (obs_toggles[1] !== 4 || bus_b.out_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_drain: got tog=%0d ovf=%b want 4 1", obs_toggles[1], bus_b.out_overflow);
        end
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus_b.out_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got %b want 0", bus_b.out_overflow);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus_a.out_pending !== 4'd1 || bus_a.out_signal !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_edge: got pend=%0d sig=%b want 1 0", bus_a.out_pending, bus_a.out_signal);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_toggles[0] !== 3 || obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL simul_total: got tog=%0d vec=%h want 3 %h", obs_toggles[0], obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus_a.out_pending !== 4'd2 || bus_a.out_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: got pend=%0d busy=%b want 2 1", bus_a.out_pending, bus_a.out_busy);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_vec(0) !== 7'h00) begin
            n_fail++;
            $display("FAIL midrst_clear: got %h want 00", obs_vec(0));
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_toggles[0] !== 1 || obs_vec(0) !== 7'h00) begin
            n_fail++;
            $display("FAIL midrst_quiet: got tog=%0d vec=%h want 1 00", obs_toggles[0], obs_vec(0));
        end
    endtask

    task automatic test_random();
        logic p, c, r;
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 9) < 4);
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 249) == 0);
            step(p, c, r);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs_toggles[d] !== m_toggles[d]) begin
                n_fail++;
                $display("FAIL random_toggles dut%0d: got %0d want %0d", d, obs_toggles[d], m_toggles[d]);
            end
        end
    endtask

    initial begin
        bus_a.in_pulse = 1'b0; bus_a.clr_overflow = 1'b0;
        bus_b.in_pulse = 1'b0; bus_b.clr_overflow = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_since[d] = 1000; m_pending[d] = 0; m_sig[d] = 1'b0; m_ovf[d] = 1'b0;
            obs_prev[d] = 1'b0;
        end
        clear_counts();
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aidan_mcnay_change_emit.md
Name: aidan_mcnay_change_emit

Overview:
- Transmit end of the change-signalling link: converts single-cycle event pulses into level transitions on one wire.
- Each accepted event toggles out_signal exactly once, so a downstream aidan_mcnay_change_detect reproduces one pulse per event.
- Bursts of events are counted and replayed with a guaranteed minimum hold between toggles, so a slower or synchronised receiver never misses a change.
- Sits on the output side of the prime-detection datapath, for example signalling "result ready" events off-chip.

Parameters:
- p_min_hold, default 4: minimum clock cycles out_signal stays stable after each toggle. Legal range is 1 or more.
- p_cnt_bits, default 4: width of the pending-event counter. Maximum backlog is 2**p_cnt_bits - 1.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_pulse  input  1  event request; each cycle it is high counts as one event.
- clr_overflow  input  1  clears the sticky overflow flag.
- out_signal  output  1  toggle-encoded event line.
- out_busy  output  1  high while a hold is in progress or any events are pending.
- out_pending  output  p_cnt_bits  number of queued events not yet emitted.
- out_overflow  output  1  sticky flag: an event was dropped because the counter was saturated.

Behaviour:
- Reset: when rst is sampled high at a clock edge, the following apply after that edge.
  - out_signal = 0, out_pending = 0, out_overflow = 0, out_busy = 0.
  - Hold counter = 0, state = IDLE.
  - rst has priority over every other input, including mid-hold and with a backlog; pending events are discarded.
- States:
  - IDLE: no hold is active. If in_pulse is high, toggle out_signal at this edge and go to HOLD with hold_cnt = p_min_hold - 1. The new level is visible in the next cycle, so latency is 1 cycle.
  - HOLD with hold_cnt > 0: decrement hold_cnt and do not toggle. A high in_pulse increments pending.
  - HOLD with hold_cnt == 0:
    - If pending > 0, or in_pulse is high: toggle, reload hold_cnt = p_min_hold - 1 and stay in HOLD. The consumed event is taken from pending if pending > 0, otherwise it is the in_pulse event.
    - Otherwise go to IDLE.
- Toggle spacing: consecutive toggles are at least p_min_hold edges apart.
  - Example with p_min_hold = 4: toggles can land on edges 1, 5, 9, and so on.
  - With p_min_hold = 1, one toggle per cycle is possible, giving full throughput with no backlog.
- Pending arithmetic:
  - Next pending = pending + (in_pulse not consumed directly) - (toggle drew from pending).
  - A pulse arriving in the same cycle as a toggle that drew from pending leaves pending unchanged.
  - Saturation: if pending == 2**p_cnt_bits - 1 and an unconsumed in_pulse arrives, pending holds and out_overflow is set to 1. No wrap-around.
- Overflow flag:
  - out_overflow stays set until clr_overflow or rst.
  - If clr_overflow and a new overflow occur in the same cycle, set wins and the flag stays 1.
- out_busy = (state == HOLD) OR (pending != 0). Registered-state derived, with no combinational path from in_pulse.
- out_pending and out_overflow are driven directly from registers.

Decomposition:
- Shared definitions file (Verilog header with an include guard in the codebase style): state encodings LP_IDLE = 1'b0 and LP_HOLD = 1'b1, plus the hold-counter width function $clog2(p_min_hold) with a floor of 1 bit.
- One sub-module, aidan_mcnay_sat_counter:
  - Parameterised-width up/down counter with inc and dec inputs.
  - Saturates at all-ones and reports a sat_drop pulse.
  - The top-level FSM and hold counter stay in aidan_mcnay_change_emit.

Test Plan:
- Reset: drive in_pulse = 1 with rst = 1 for 3 cycles, then release -> out_signal = 0, out_pending = 0, out_busy = 0, and no toggle while rst is high.
- Single event, p_min_hold = 4: one in_pulse at cycle 10 -> out_signal rises at cycle 11; out_busy is high for cycles 11-14 and low from cycle 15; exactly one pulse appears on a chained aidan_mcnay_change_detect.
- Burst, p_min_hold = 4: in_pulse high at cycles 10-13 -> toggles at cycles 11, 15, 19, 23; out_pending peaks at 3 and drains to 0; final out_signal = 0.
- Saturation, p_cnt_bits = 2, p_min_hold = 8: 6 consecutive pulses -> pending saturates at 3, out_overflow = 1, only 4 toggles in total; clr_overflow then clears the flag.
- Simultaneous events: a pulse arrives exactly on a pending-drain toggle edge -> pending is unchanged for that cycle, and total toggles equal total pulses.
- Mid-operation reset: assert rst during HOLD with pending = 2 -> outputs return to reset values one edge later, and no further toggles occur.
